// File: rtl/jtbubl_snd_comm_if.sv
// Main CPU bus into the sound mailbox register window.
interface jtbubl_snd_comm_if;
   logic       cs;
   logic [1:0] addr;
   logic       wr_n;
   logic       rd_n;
   logic [7:0] din;
   logic [7:0] dout;

   modport master (output cs, addr, wr_n, rd_n, din, input dout);
   modport slave  (input cs, addr, wr_n, rd_n, din, output dout);
endinterface

// File: rtl/jtbubl_snd_comm.sv
// Main-CPU-side sound mailbox: command latch with strobe, reply capture,
// handshake status, reply interrupt and sound subsystem reset control.
module jtbubl_snd_comm #(
   parameter int RST_CNT = 16,
   parameter bit INT_DEF = 1'b0
) (
   input  logic               clk,
   input  logic               rstn,
   jtbubl_snd_comm_if.slave   bus,
   output logic [7:0]         snd_latch,
   output logic               snd_stb,
   input  logic               snd_flag,
   input  logic [7:0]         main_latch,
   input  logic               main_stb,
   output logic               main_flag,
   output logic               main_int_n,
   output logic               snd_rstn
);
   localparam logic [7:0] RST_LD = 8'(RST_CNT);

   logic       wr_q, rd_q, stb_q;
   logic       srst, int_en;
   logic [7:0] reply, cnt;

   logic       wr_act, rd_act, wr_edge, rd_edge, stb_edge, clr;
   logic       srst_nxt, int_en_nxt, flag_nxt;
   logic [7:0] cnt_nxt, rd_mux;

   // Edge detection, register-map decode and next-state of the control bits.
   // srst forces the flag low with priority; a capture beats a clear.
   always_comb begin
      wr_act     = bus.cs & ~bus.wr_n;
      rd_act     = bus.cs & ~bus.rd_n;
      wr_edge    = wr_act & ~wr_q;
      rd_edge    = rd_act & ~rd_q;
      stb_edge   = main_stb & ~stb_q;
      srst_nxt   = srst;
      int_en_nxt = int_en;
      if (wr_edge && bus.addr == 2'd2) begin
         srst_nxt   = bus.din[0];
         int_en_nxt = bus.din[1];
      end
      clr = (wr_edge && bus.addr == 2'd3) || (rd_edge && bus.addr == 2'd0);
      flag_nxt = main_flag;
      if (clr)      flag_nxt = 1'b0;
      if (stb_edge) flag_nxt = 1'b1;
      if (srst_nxt) flag_nxt = 1'b0;
      cnt_nxt = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
      case (bus.addr)
         2'd0:    rd_mux = reply;
         2'd1:    rd_mux = {5'b0, int_en, main_flag, snd_flag};
         2'd2:    rd_mux = {6'b0, int_en, srst};
         default: rd_mux = 8'hff;
      endcase
   end

   // State registers; edge registers reset to the active level so a strobe
   // held through reset release is not taken as a new access.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_q       <= 1'b1;
         rd_q       <= 1'b1;
         stb_q      <= 1'b1;
         snd_latch  <= 8'd0;
         snd_stb    <= 1'b0;
         bus.dout   <= 8'hff;
         main_flag  <= 1'b0;
         main_int_n <= 1'b1;
         snd_rstn   <= 1'b0;
         srst       <= 1'b0;
         int_en     <= INT_DEF;
         reply      <= 8'd0;
         cnt        <= RST_LD;
      end else begin
         wr_q       <= wr_act;
         rd_q       <= rd_act;
         stb_q      <= main_stb;
         snd_stb    <= wr_edge && bus.addr == 2'd0;
         if (wr_edge && bus.addr == 2'd0) snd_latch <= bus.din;
         if (rd_act) bus.dout <= rd_mux;
         if (stb_edge) reply <= main_latch;
         main_flag  <= flag_nxt;
         main_int_n <= ~(main_flag & int_en);
         srst       <= srst_nxt;
         int_en     <= int_en_nxt;
         cnt        <= cnt_nxt;
         snd_rstn   <= (cnt_nxt == 8'd0) && !srst_nxt;
      end
   end
endmodule
